polar_enc_unit: RTL

- Systematic-free (non-systematic) polar encoder for N=64 codewords, operating on 16-bit beats that match the decoder's 16-bit bit bus.
- It collects four u-vector beats and applies the polar transform x = u·F^{⊗6}, with F = [[1,0],[1,1]].
- It forces frozen positions to 0 and streams four codeword beats out under valid/ready handshakes.
- It sits at the transmit side of the polar link and feeds the channel model or testbench that drives the SC/fast-SSC decoder, including its SPC node units.

---
 rtl/polar_enc_unit_pkg.sv | 17 +
 rtl/polar_enc_unit_f16.sv | 28 ++
 rtl/polar_enc_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/polar_enc_unit_pkg.sv
// Shared constants and state type for the N=64 polar encoder.
package polar_enc_unit_pkg;

    localparam int N_CODE     = 64;
    localparam int BEAT_W     = 16;
    localparam int BEATS      = N_CODE / BEAT_W;
    localparam int CNT_W      = 2;
    localparam int F16_STAGES = 4;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_OUT  = 1'b1
    } state_t;

endpackage

// File: rtl/polar_enc_unit_f16.sv
// 16-point polar butterfly (F^{x4}), purely combinational.
// Works in index space: index b lives on bit [15-b] of the bus.
// A lower index absorbs the value of its partner with the stage bit set.
module polar_enc_f16
    import polar_enc_unit_pkg::*;
(
    input  logic [BEAT_W-1:0] u_i,
    output logic [BEAT_W-1:0] e_o
);

    logic [F16_STAGES:0][BEAT_W-1:0] v;

    for (genvar i = 0; i < BEAT_W; i++) begin : g_io
        assign v[0][i]          = u_i[BEAT_W-1-i];
        assign e_o[BEAT_W-1-i]  = v[F16_STAGES][i];
    end

    for (genvar s = 0; s < F16_STAGES; s++) begin : g_stage
        for (genvar i = 0; i < BEAT_W; i++) begin : g_bf
            if (((i >> s) & 1) == 0) begin : g_xor
                assign v[s+1][i] = v[s][i] ^ v[s][i + (1 << s)];
            end else begin : g_pass
                assign v[s+1][i] = v[s][i];
            end
        end
    end

endmodule

// File: rtl/polar_enc_unit.sv
// Non-systematic N=64 polar encoder: loads four u beats, encodes on the
// fourth accepted beat, then streams four codeword beats out.
//
// state  | meaning
// S_LOAD | accepting u beats, cnt = index of next beat
// S_OUT  | presenting x_buf[cnt], waiting for out_ready
module polar_enc_unit
    import polar_enc_unit_pkg::*;
#(
    parameter logic [N_CODE-1:0] FROZEN_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BEAT_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BEAT_W-1:0]  u_buf_q [BEATS-1];
    logic [BEAT_W-1:0]  x_buf_q [BEATS];

    logic [BEAT_W-1:0]  beat_mask [BEATS];
    logic [BEAT_W-1:0]  in_masked;
    logic [BEAT_W-1:0]  e [BEATS];
    logic [BEAT_W-1:0]  x_d [BEATS];
    logic               load_fire;

    for (genvar k = 0; k < BEATS; k++) begin : g_mask
        assign beat_mask[k] = FROZEN_MASK[N_CODE-1-BEAT_W*k -: BEAT_W];
    end

    assign in_masked = in_data & ~beat_mask[cnt_q];
    assign load_fire = (state_q == S_LOAD) && in_valid;

    // Beat 3 is encoded straight from the input bus so it never needs a buffer.
    polar_enc_f16 u_f16_0 (.u_i(u_buf_q[0]), .e_o(e[0]));
    polar_enc_f16 u_f16_1 (.u_i(u_buf_q[1]), .e_o(e[1]));
    polar_enc_f16 u_f16_2 (.u_i(u_buf_q[2]), .e_o(e[2]));
    polar_enc_f16 u_f16_3 (.u_i(in_masked),  .e_o(e[3]));

    // Inter-beat stage: same butterfly rule applied across the four beats.
    always_comb begin
        x_d[0] = e[0] ^ e[1] ^ e[2] ^ e[3];
        x_d[1] = e[1] ^ e[3];
        x_d[2] = e[2] ^ e[3];
        x_d[3] = e[3];
    end

    // State, counter and data buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            for (int k = 0; k < BEATS - 1; k++) u_buf_q[k] <= '0;
            for (int k = 0; k < BEATS; k++)     x_buf_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_fire) begin
                if (cnt_q == 2'd0) u_buf_q[0] <= in_masked;
                if (cnt_q == 2'd1) u_buf_q[1] <= in_masked;
                if (cnt_q == 2'd2) u_buf_q[2] <= in_masked;
                if (cnt_q == LAST_BEAT) begin
                    for (int k = 0; k < BEATS; k++) x_buf_q[k] <= x_d[k];
                end
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = x_buf_q[cnt_q];
                out_last  = (cnt_q == LAST_BEAT);
                if (out_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign busy = (state_q != S_LOAD) || (cnt_q != '0);

endmodule
